// File: rtl/execute_pkg.sv
// Shared types for the execute stage: ALU and M-extension op encodings, branch types and the
// multiply/divide FSM states.
package execute_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic md_is_div(muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic md_a_signed(muldiv_op_t op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_b_signed(muldiv_op_t op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/execute_m_muldiv_iter.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring divide on operand
// magnitudes, one step per cycle, with sign fix-up and divide special cases.
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    muldiv_op_t        op_q, op_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   spec_q, spec_d;

    logic              a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quot, rem;

    assign a_neg    = md_a_signed(op) & a[XLEN-1];
    assign b_neg    = md_b_signed(op) & b[XLEN-1];
    assign a_abs    = a_neg ? -a : a;
    assign b_abs    = b_neg ? -b : b;
    assign div_zero = md_is_div(op) && (b == '0);
    assign div_ovf  = (op == MD_DIV || op == MD_REM) && (a == MIN_NEG) && (b == '1);

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = rem_sh - {1'b0, opnd_q};
    assign div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        special_d = special_q;
        spec_d    = spec_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy      = 1'b1;
                    op_d      = op;
                    cnt_d     = '0;
                    neg_d     = a_neg ^ b_neg;
                    rneg_d    = a_neg;
                    special_d = div_zero | div_ovf;
                    if (div_zero) begin
                        spec_d  = op[1] ? a : '1;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        spec_d  = op[1] ? '0 : a;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        if (md_is_div(op)) begin
                            acc_d  = {{XLEN{1'b0}}, a_abs};
                            opnd_d = b_abs;
                        end else begin
                            acc_d  = {{XLEN{1'b0}}, b_abs};
                            opnd_d = a_abs;
                        end
                    end
                end
            end
            BUSY: begin
                busy  = 1'b1;
                acc_d = md_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            busy    = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= MD_MUL;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            special_q <= special_d;
            spec_q    <= spec_d;
        end
    end

    // Sign fix-up: negating the full product keeps both halves correct
    assign prod = neg_q ? -acc_q : acc_q;
    assign quot = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        result = '0;
        if (special_q) begin
            result = spec_q;
        end else begin
            case (op_q)
                MD_MUL:                      result = prod[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:             result = quot;
                MD_REM, MD_REMU:             result = rem;
                default:                     result = '0;
            endcase
        end
    end

endmodule

// File: rtl/execute_m.sv
// Execute stage: ALU, operand muxes, branch comparator and target adder, plus the iterative
// multiply/divide unit that stalls the pipeline while it runs.
module execute_m
    import execute_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidE,
    input  logic            FlushE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic [2:0]      BranchTypeE,
    input  logic [3:0]      ALUControlE,
    input  logic            MulDivE,
    input  logic [2:0]      MulDivOpE,
    input  logic            ALUSrcAE,
    input  logic            ALUSrcBE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ExtImmE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] WriteDataE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            StallE
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_op_t         alu_op;
    branch_type_t    br_type;
    logic [XLEN-1:0] srca, srcb, alu_result, md_result;
    logic [SHW-1:0]  shamt;
    logic            eq, lt, ltu, taken;
    logic            md_start, md_busy, md_done;

    assign alu_op  = alu_op_t'(ALUControlE);
    assign br_type = branch_type_t'(BranchTypeE);
    assign srca    = ALUSrcAE ? SrcAE : PCE;
    assign srcb    = ALUSrcBE ? ExtImmE : WriteDataE;
    assign shamt   = srcb[SHW-1:0];

    assign eq  = (srca == srcb);
    assign lt  = ($signed(srca) < $signed(srcb));
    assign ltu = (srca < srcb);

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:   alu_result = srca + srcb;
            ALU_SUB:   alu_result = srca - srcb;
            ALU_AND:   alu_result = srca & srcb;
            ALU_OR:    alu_result = srca | srcb;
            ALU_XOR:   alu_result = srca ^ srcb;
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, ltu};
            ALU_SLL:   alu_result = srca << shamt;
            ALU_SRL:   alu_result = srca >> shamt;
            ALU_SRA:   alu_result = $signed(srca) >>> shamt;
            ALU_PASSB: alu_result = srcb;
            default:   alu_result = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = ~eq;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = ~lt;
            BR_BLTU: taken = ltu;
            BR_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE    = ValidE & ~FlushE & ~MulDivE & (JumpE | (BranchE & taken));
    assign PCTargetE = PCE + ExtImmE;

    // M ops take rs1/rs2 directly, bypassing the operand muxes
    assign md_start = ValidE & MulDivE & ~FlushE;

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .flush  (FlushE),
        .op     (muldiv_op_t'(MulDivOpE)),
        .a      (SrcAE),
        .b      (WriteDataE),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign StallE     = ~rst & ~FlushE & md_busy;
    assign ALUResultE = MulDivE ? (md_done ? md_result : '0) : alu_result;

endmodule

// File: tb/tb_execute_m.sv
// Scoreboard bench for execute_m: drivers queue expected responses, a negedge monitor compares.
module tb_execute_m;
    import execute_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int K_RES = 0, K_STALL = 1, K_BR = 2, K_MD = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            ValidE, FlushE, JumpE, BranchE, MulDivE, ALUSrcAE, ALUSrcBE;
    logic [2:0]      BranchTypeE, MulDivOpE;
    logic [3:0]      ALUControlE;
    logic [XLEN-1:0] PCE, ExtImmE, SrcAE, WriteDataE;
    logic            PCSrcE, StallE;
    logic [XLEN-1:0] ALUResultE, PCTargetE;

    execute_m #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE), .JumpE(JumpE),
        .BranchE(BranchE), .BranchTypeE(BranchTypeE), .ALUControlE(ALUControlE),
        .MulDivE(MulDivE), .MulDivOpE(MulDivOpE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .PCE(PCE), .ExtImmE(ExtImmE), .SrcAE(SrcAE), .WriteDataE(WriteDataE),
        .PCSrcE(PCSrcE), .ALUResultE(ALUResultE), .PCTargetE(PCTargetE), .StallE(StallE)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
        logic [31:0] exp2;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    passed = 0;
    int    stall_cnt = 0;
    logic  chk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        item_t it;
        if (chk || (!rst && !FlushE && ValidE && MulDivE && !StallE)) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_underflow: got an output, expected none");
            end else begin
                it = sb.pop_front();
                case (it.kind)
                    K_RES: begin
                        check(it.name, ALUResultE, it.exp);
                        check({it.name, "_stall"}, StallE, 0);
                    end
                    K_STALL: check(it.name, StallE, it.exp);
                    K_BR: begin
                        check(it.name, PCSrcE, it.exp);
                        check({it.name, "_tgt"}, PCTargetE, it.exp2);
                    end
                    default: begin
                        check(it.name, ALUResultE, it.exp);
                        check({it.name, "_stalls"}, stall_cnt, it.exp2);
                    end
                endcase
            end
        end
        if (StallE && !rst && !FlushE) stall_cnt++;
        else stall_cnt = 0;
    end

    task automatic bubble();
        ValidE = 0; FlushE = 0; JumpE = 0; BranchE = 0; MulDivE = 0;
    endtask

    task automatic post(input item_t it);
        sb.push_back(it);
        chk = 1'b1;
        @(negedge clk);
        #1 chk = 1'b0;
    endtask

    task automatic stall_chk(input string name, input logic exp);
        item_t it;
        it.kind = K_STALL; it.name = name; it.exp = {31'd0, exp}; it.exp2 = '0;
        post(it);
    endtask

    task automatic alu_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic imm, input logic [31:0] exp);
        item_t it;
        @(posedge clk); #1;
        bubble();
        ValidE = 1; ALUControlE = op; ALUSrcAE = 1; SrcAE = a; ALUSrcBE = imm;
        if (imm) begin ExtImmE = b; WriteDataE = 32'hDEADBEEF; end
        else begin WriteDataE = b; ExtImmE = 32'h0BAD0BAD; end
        it.kind = K_RES; it.name = name; it.exp = exp; it.exp2 = '0;
        post(it);
    endtask

    task automatic br_chk(input string name, input logic valid, input logic jump,
                          input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic exp_src, input logic [31:0] exp_tgt);
        item_t it;
        @(posedge clk); #1;
        bubble();
        ValidE = valid; JumpE = jump; BranchE = ~jump; BranchTypeE = bt;
        ALUControlE = ALU_SUB; ALUSrcAE = 1; ALUSrcBE = 0; SrcAE = a; WriteDataE = b;
        PCE = pc; ExtImmE = imm;
        it.kind = K_BR; it.name = name; it.exp = {31'd0, exp_src}; it.exp2 = exp_tgt;
        post(it);
    endtask

    task automatic md_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int stalls);
        item_t it;
        bit    seen = 0;
        @(posedge clk); #1;
        bubble();
        ValidE = 1; MulDivE = 1; MulDivOpE = op; SrcAE = a; WriteDataE = b;
        ALUSrcAE = 0; ALUSrcBE = 1; PCE = 32'h1000; ExtImmE = 32'h55;
        it.kind = K_MD; it.name = name; it.exp = exp; it.exp2 = stalls;
        sb.push_back(it);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!StallE) begin seen = 1; break; end
        end
        if (!seen) begin
            total++;
            $display("FAIL %s_timeout: StallE still 1 after 100 cycles, expected 0", name);
        end
    endtask

    initial begin : stim
        item_t it;
        rst = 1; bubble();
        BranchTypeE = 0; ALUControlE = 0; MulDivOpE = 0; ALUSrcAE = 0; ALUSrcBE = 0;
        PCE = 0; ExtImmE = 0; SrcAE = 0; WriteDataE = 0;
        // A would-be start during reset must not stall
        ValidE = 1; MulDivE = 1; MulDivOpE = MD_DIV; SrcAE = 32'd9; WriteDataE = 32'd2;
        #2 stall_chk("reset_stall", 1'b0);
        @(posedge clk); #1 rst = 0; bubble();

        alu_chk("add_imm", ALU_ADD, 32'd5, 32'hFFFFFFFD, 1, 32'd2);
        alu_chk("sub",     ALU_SUB, 32'd5, 32'd7, 0, 32'hFFFFFFFE);
        alu_chk("and",     ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0);
        alu_chk("or",      ALU_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hFFF0FFF0);
        alu_chk("xor",     ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hFF00FF00);
        alu_chk("slt",     ALU_SLT, 32'hFFFFFFFF, 32'd1, 0, 32'd1);
        alu_chk("sltu",    ALU_SLTU, 32'hFFFFFFFF, 32'd1, 0, 32'd0);
        alu_chk("sll",     ALU_SLL, 32'd1, 32'h3F, 1, 32'h80000000);
        alu_chk("srl",     ALU_SRL, 32'h80000000, 32'd4, 1, 32'h08000000);
        alu_chk("sra",     ALU_SRA, 32'h80000000, 32'd4, 1, 32'hF8000000);
        alu_chk("passb",   ALU_PASSB, 32'h1, 32'h12345000, 1, 32'h12345000);

        br_chk("blt",    1, 0, BR_BLT,  32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 1, 32'h120);
        br_chk("bltu",   1, 0, BR_BLTU, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 0, 32'h120);
        br_chk("blt_nv", 0, 0, BR_BLT,  32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 0, 32'h120);
        br_chk("beq",    1, 0, BR_BEQ,  32'd5, 32'd5, 32'hFFFFFFF0, 32'h20, 1, 32'h10);
        br_chk("jump",   1, 1, BR_BNE,  32'd5, 32'd5, 32'h200, 32'hFFFFFFFC, 1, 32'h1FC);

        md_op("mul",    MD_MUL,    32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 33);
        md_op("mulh",   MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        md_op("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        md_op("mulhu",  MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        md_op("div",    MD_DIV,    32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        md_op("rem",    MD_REM,    32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        md_op("divu",   MD_DIVU,   32'd100, 32'd7, 32'd14, 33);
        md_op("remu",   MD_REMU,   32'd100, 32'd7, 32'd2, 33);
        md_op("divu_z", MD_DIVU,   32'd9, 32'd0, 32'hFFFFFFFF, 1);
        md_op("rem_z",  MD_REM,    32'd9, 32'd0, 32'd9, 1);
        md_op("div_ov", MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        md_op("rem_ov", MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        // Flush partway through BUSY
        @(posedge clk); #1;
        bubble(); ValidE = 1; MulDivE = 1; MulDivOpE = MD_MUL; SrcAE = 32'd5; WriteDataE = 32'd6;
        repeat (11) @(negedge clk);
        @(posedge clk); #1 FlushE = 1;
        stall_chk("flush_stall", 1'b0);
        @(posedge clk); #1 bubble();
        stall_chk("flush_idle", 1'b0);

        // Reset pulsed entirely between clock edges mid-BUSY
        @(posedge clk); #1;
        bubble(); ValidE = 1; MulDivE = 1; MulDivOpE = MD_DIVU; SrcAE = 32'd50; WriteDataE = 32'd3;
        repeat (8) @(negedge clk);
        #1 rst = 1;
        #2 rst = 0; bubble();
        @(posedge clk); #1;
        stall_chk("rst_idle", 1'b0);
        md_op("mul_post", MD_MUL, 32'd3, 32'd4, 32'd12, 33);

        @(posedge clk); #1 bubble();
        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            total++;
            $display("FAIL %s: got no response, expected one", it.name);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/execute_m.md
# execute_m

Parametrised next-generation execute stage for the 5-stage RV pipeline: the RV32I/RV64I ALU and branch resolution, plus an iterative M-extension multiply/divide unit. Sits between the ID/EX and EX/MEM pipeline registers. Multi-cycle M ops raise `StallE` to the hazard unit, which freezes F/D/E and bubbles M until the result is ready.

## Interface
- `XLEN`, default 32: datapath width; 32 or 64.
- `clk`  in  1: pipeline clock.
- `rst`  in  1: asynchronous, active-high reset.
- `ValidE`  in  1: E holds a real instruction, not a bubble.
- `FlushE`  in  1: kill the instruction in E, from the hazard unit.
- `JumpE`, `BranchE`  in  1 each: control from the decoder.
- `BranchTypeE`  in  3: branch funct3, BEQ/BNE/BLT/BGE/BLTU/BGEU.
- `ALUControlE`  in  4: ALU op, `alu_op_t`.
- `MulDivE`  in  1: the instruction is an M-extension op.
- `MulDivOpE`  in  3: M funct3, MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- `ALUSrcAE`  in  1: 0 selects `PCE`, 1 selects `SrcAE`.
- `ALUSrcBE`  in  1: 0 selects `WriteDataE`, 1 selects `ExtImmE`.
- `PCE`, `ExtImmE`, `SrcAE`, `WriteDataE`  in  XLEN each: `SrcAE` and `WriteDataE` are already forwarded by the hazard unit.
- `PCSrcE`  out  1: redirect fetch.
- `ALUResultE`  out  XLEN: ALU or M result.
- `PCTargetE`  out  XLEN: `PCE + ExtImmE`, modulo 2^XLEN.
- `StallE`  out  1: M op in progress; hold the pipeline.

## Operation
- **ALU ops:** ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB (LUI).
  - Shift amount is `SrcB[$clog2(XLEN)-1:0]`.
  - Results wrap modulo 2^XLEN.
- **Branch resolution:** a signed/unsigned comparator on SrcA/SrcB evaluates `BranchTypeE`.
  - `PCSrcE = ValidE & ~FlushE & (JumpE | (BranchE & taken))`.
  - `PCSrcE` is 0 whenever `MulDivE` is 1.
- **M operands:** always `SrcAE` (rs1) and `WriteDataE` (rs2); the operand muxes are bypassed.
- **FSM states:** IDLE, BUSY, DONE.
  - `start = ValidE & MulDivE & ~FlushE` in IDLE.
- **IDLE:**
  - On start, latch the operands and op. Signed ops take absolute values and record the result sign.
  - Go to BUSY with counter 0.
  - Special cases go straight to DONE with a precomputed result:
    - Divide by zero: quotient all-ones, remainder = dividend.
    - Signed overflow (min / -1): quotient = dividend, remainder 0.
- **BUSY:**
  - Multiply: one radix-2 shift-add step per cycle into a 2·XLEN accumulator.
  - Divide: one restoring step per cycle.
  - When counter == XLEN-1, go to DONE.
- **DONE:**
  - Apply the sign fix-up and select the output:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half. MULHSU treats only rs1 as signed.
    - DIV/DIVU: quotient; REM/REMU: remainder. The remainder takes the dividend's sign.
  - `ALUResultE` = M result. Return to IDLE on the next edge.
- **StallE:**
  - `StallE = ~rst & ~FlushE & ((IDLE & start) | BUSY)`.
  - `StallE` is 0 in DONE, so the instruction advances with its result.
- **FlushE:**
  - FlushE in any state forces IDLE on the next edge and discards the partial result.
  - `StallE` drops in the same cycle.
- **Reset:** asynchronous; takes effect mid-operation.
  - State goes to IDLE; counter, accumulator and result registers go to 0.
- **Outputs in/after reset:**
  - `StallE` = 0 while `rst` is high.
  - `PCSrcE`, `ALUResultE` and `PCTargetE` are combinational from the inputs.

## Timing
- ALU, branch and `PCTargetE` results are combinational, with zero added latency.
- Normal M op: E occupancy is XLEN+2 cycles.
  - `StallE` is high for XLEN+1 cycles: the IDLE-start cycle plus XLEN BUSY cycles.
  - The result is valid in the DONE cycle.
- Special-case divide: `StallE` is high for 1 cycle, then DONE.
- Back-to-back M ops: the second starts in the cycle after DONE. That cycle is in IDLE.

## Structure
- Package `execute_pkg` holds:
  - `alu_op_t` (4-bit enum).
  - `muldiv_op_t` (3-bit, funct3 encoding).
  - `branch_type_t`.
  - `md_state_t` {IDLE, BUSY, DONE}.
- Sub-module `muldiv_iter`:
  - Contains the FSM, counter, accumulator, sign handling and special cases.
  - Ports: clk, rst, start, flush, op, a, b, busy, done, result.
  - The top level holds the ALU, operand muxes, comparator and output mux.

## Test plan
- **ADD with immediate:** ADD, SrcAE=5, ALUSrcBE=1, ExtImmE=0xFFFFFFFD → `ALUResultE`=2, `StallE`=0.
- **Multiply:**
  - MUL 7×0xFFFFFFFA → `StallE` high exactly 33 cycles, then `ALUResultE`=0xFFFFFFD6 in DONE.
  - MULH 0x80000000² → 0x40000000.
  - MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
- **Signed divide/remainder:**
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
- **Divide special cases:**
  - DIVU 9/0 → 0xFFFFFFFF, `StallE` high 1 cycle.
  - REM 9/0 → 9.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- **Branches:**
  - BLT 0xFFFFFFFF vs 1, PCE=0x100, ExtImmE=0x20 → `PCSrcE`=1, `PCTargetE`=0x120.
  - BLTU same operands → `PCSrcE`=0.
  - `ValidE`=0 → `PCSrcE`=0.
- **Flush and reset mid-operation:**
  - FlushE in BUSY cycle 10 → IDLE next edge, `StallE`=0 in the same cycle.
  - `rst` pulsed mid-BUSY → IDLE immediately.
  - A subsequent MUL 3×4 → 12 after 33 stall cycles.
